// File: rtl/phys_reg_file_mp_pkg.sv
// Shared parameters and helpers for the multi-port physical register file.
package phys_reg_file_mp_pkg;

    // Packed multi-port buses carry port 0 in the least-significant slice.
    localparam int unsigned PORT0_LSB = 0;

    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned port_lsb(int unsigned port, int unsigned width);
        return PORT0_LSB + port * width;
    endfunction

endpackage

// File: rtl/phys_reg_file_mp_if.sv
// Rename/issue/writeback bus bundle for the physical register file.
interface phys_reg_file_mp_if
    import phys_reg_file_mp_pkg::*;
#(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_WR    = 2,
    parameter int unsigned NUM_RD    = 4,
    parameter int unsigned NUM_ALLOC = 2
);
    localparam int unsigned IDX_W = idx_w(NUM_PREGS);

    logic                        stall;
    logic                        flush;
    logic [NUM_PREGS-1:0]        flush_ready;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR*IDX_W-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0]    wr_data;
    logic [NUM_ALLOC-1:0]        alloc_en;
    logic [NUM_ALLOC*IDX_W-1:0]  alloc_addr;
    logic [NUM_RD*IDX_W-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0]    rd_data;
    logic [NUM_RD-1:0]           rd_ready;
    logic [NUM_PREGS-1:0]        ready_vec;

    modport master (
        output stall, flush, flush_ready, wr_en, wr_addr, wr_data,
        output alloc_en, alloc_addr, rd_addr,
        input  rd_data, rd_ready, ready_vec
    );

    modport slave (
        input  stall, flush, flush_ready, wr_en, wr_addr, wr_data,
        input  alloc_en, alloc_addr, rd_addr,
        output rd_data, rd_ready, ready_vec
    );

endinterface

// File: rtl/phys_reg_file_mp_ready_table.sv
// Per-register ready bits: flush restore, then writeback set, with allocation clear winning.
module prf_ready_table
    import phys_reg_file_mp_pkg::*;
#(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned NUM_WR    = 2,
    parameter int unsigned NUM_ALLOC = 2,
    parameter int unsigned IDX_W     = idx_w(NUM_PREGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic [NUM_PREGS-1:0]       flush_ready_i,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*IDX_W-1:0]    wr_addr_i,
    input  logic [NUM_ALLOC-1:0]       alloc_en_i,
    input  logic [NUM_ALLOC*IDX_W-1:0] alloc_addr_i,
    output logic [NUM_PREGS-1:0]       ready_o
);

    logic [NUM_PREGS-1:0] ready_q, ready_d;

    always_comb begin
        ready_d = ready_q;
        if (flush_i) begin
            ready_d = flush_ready_i;
        end
        // In-flight writebacks land even on a flush, on top of the restored vector.
        if (flush_i || !stall_i) begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (wr_en_i[i]) begin
                    ready_d[wr_addr_i[port_lsb(i, IDX_W) +: IDX_W]] = 1'b1;
                end
            end
        end
        if (!flush_i && !stall_i) begin
            for (int unsigned j = 0; j < NUM_ALLOC; j++) begin
                if (alloc_en_i[j]) begin
                    ready_d[alloc_addr_i[port_lsb(j, IDX_W) +: IDX_W]] = 1'b0;
                end
            end
        end
        ready_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= '1;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-port physical register file with ready scoreboard and same-cycle write-to-read bypass.
module phys_reg_file_mp
    import phys_reg_file_mp_pkg::*;
#(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_WR    = 2,
    parameter int unsigned NUM_RD    = 4,
    parameter int unsigned NUM_ALLOC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    phys_reg_file_mp_if.slave bus
);

    localparam int unsigned IDX_W = idx_w(NUM_PREGS);

    logic [DATA_W-1:0]    mem_q [NUM_PREGS];
    logic [DATA_W-1:0]    mem_d [NUM_PREGS];
    logic [IDX_W-1:0]     wr_addr_a [NUM_WR];
    logic [DATA_W-1:0]    wr_data_a [NUM_WR];
    logic [IDX_W-1:0]     rd_addr_a [NUM_RD];
    logic [DATA_W-1:0]    rd_data_a [NUM_RD];
    logic                 rd_rdy_a  [NUM_RD];
    logic [NUM_PREGS-1:0] ready_q;
    logic                 wr_active;

    always_comb begin
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            wr_addr_a[i] = bus.wr_addr[port_lsb(i, IDX_W) +: IDX_W];
            wr_data_a[i] = bus.wr_data[port_lsb(i, DATA_W) +: DATA_W];
        end
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_addr_a[k] = bus.rd_addr[port_lsb(k, IDX_W) +: IDX_W];
        end
    end

    // Flush overrides stall so writebacks racing a mispredict are kept.
    assign wr_active = bus.flush | ~bus.stall;

    always_comb begin
        mem_d = mem_q;
        if (wr_active) begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (bus.wr_en[i]) begin
                    mem_d[wr_addr_a[i]] = wr_data_a[i];
                end
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    prf_ready_table #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_WR    (NUM_WR),
        .NUM_ALLOC (NUM_ALLOC),
        .IDX_W     (IDX_W)
    ) u_ready_table (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (bus.stall),
        .flush_i       (bus.flush),
        .flush_ready_i (bus.flush_ready),
        .wr_en_i       (bus.wr_en),
        .wr_addr_i     (bus.wr_addr),
        .alloc_en_i    (bus.alloc_en),
        .alloc_addr_i  (bus.alloc_addr),
        .ready_o       (ready_q)
    );

    // Bypass ignores same-cycle allocation: issue sees stored state plus the write.
    always_comb begin
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_data_a[k] = mem_q[rd_addr_a[k]];
            rd_rdy_a[k]  = ready_q[rd_addr_a[k]];
            if (!bus.stall) begin
                for (int unsigned i = 0; i < NUM_WR; i++) begin
                    if (bus.wr_en[i] && (wr_addr_a[i] == rd_addr_a[k])) begin
                        rd_data_a[k] = wr_data_a[i];
                        rd_rdy_a[k]  = 1'b1;
                    end
                end
            end
            if (rd_addr_a[k] == '0) begin
                rd_data_a[k] = '0;
                rd_rdy_a[k]  = 1'b1;
            end
        end
    end

    always_comb begin
        bus.rd_data  = '0;
        bus.rd_ready = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            bus.rd_data[port_lsb(k, DATA_W) +: DATA_W] = rd_data_a[k];
            bus.rd_ready[k]                            = rd_rdy_a[k];
        end
    end

    assign bus.ready_vec = ready_q;

endmodule

// File: doc/phys_reg_file_mp.md
Name: phys_reg_file_mp

Overview:
Parametrised multi-port physical register file with an integrated ready-bit scoreboard for the out-of-order core. It generalises the current two-writer file in four ways:
- configurable depth, width, write-port and read-port counts;
- per-register ready tracking, cleared on rename allocation and set on writeback;
- same-cycle write-to-read bypass;
- flush-time restore of the ready vector.
It sits between rename/issue (alloc, read ports) and the execute/memory writeback buses (write ports).

Parameters:
NUM_PREGS, 64, number of physical registers; power of two, >= 2.
DATA_W, 32, register data width.
NUM_WR, 2, writeback ports.
NUM_RD, 4, read ports (issue operand reads).
NUM_ALLOC, 2, rename allocation ports per cycle.
IDX_W (localparam), $clog2(NUM_PREGS), physical register index width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
stall  in  1  blocks writes and allocations this cycle.
flush  in  1  mispredict recovery; loads ready vector from flush_ready.
flush_ready  in  NUM_PREGS  ready vector to restore on flush.
wr_en  in  NUM_WR  per-port write enable.
wr_addr  in  NUM_WR*IDX_W  packed write indices, port 0 in LSBs.
wr_data  in  NUM_WR*DATA_W  packed write data.
alloc_en  in  NUM_ALLOC  per-port allocation strobe.
alloc_addr  in  NUM_ALLOC*IDX_W  packed indices of newly allocated destinations.
rd_addr  in  NUM_RD*IDX_W  packed read indices.
rd_data  out  NUM_RD*DATA_W  read data, combinational.
rd_ready  out  NUM_RD  ready bit of each read index, combinational.
ready_vec  out  NUM_PREGS  full ready vector (for checkpointing by rename).

Behaviour:
- Reset (asynchronous, reset==0):
  - all data entries = 0;
  - ready_vec = all ones;
  - outputs reflect this immediately: rd_data = 0, rd_ready = 1.
- Register 0 is hardwired:
  - reads return 0 with ready = 1;
  - writes, allocations and flush bits for index 0 are ignored.
- Write, on the rising edge when stall==0 and wr_en[i]==1:
  - data[wr_addr[i]] <= wr_data[i];
  - ready[wr_addr[i]] <= 1.
- Write-port conflict (two ports, same index, same cycle): the highest-numbered port wins, for both data and ready.
- Allocation, on the rising edge when stall==0 and alloc_en[j]==1:
  - ready[alloc_addr[j]] <= 0;
  - data is untouched.
- Write and allocation to the same index in the same cycle: allocation wins, so ready = 0 while the written data is still stored. The writer is a stale producer; the new producer is pending.
- Flush, on the rising edge when flush==1:
  - ready <= flush_ready, with bit 0 forced to 1;
  - flush overrides stall and all allocations that cycle;
  - writes in the same cycle still update data and set ready, applied after the restore. In-flight writebacks must not be lost.
- Stall with no flush: data and ready are fully frozen.
- Reads are fully combinational, zero latency.
- Bypass: if any wr_en[i] is active with wr_addr[i]==rd_addr[k] (k != 0 index) and stall==0:
  - rd_data[k] = wr_data[i], highest i wins;
  - rd_ready[k] = 1.
  This makes same-cycle writeback visible to issue. No bypass while stall==1.
- Bypass does not override an allocation of the same index in the same cycle; rd_ready reflects stored state plus the write only.
- Out-of-range indices cannot occur; NUM_PREGS is a power of two.
- No debug display in RTL. Debug dump is under the PHYSREG define, printing index, value and ready for all entries on each rising edge.

Decomposition:
- Shared package:
  - IDX_W computation helper;
  - a pack/unpack convention constant for port ordering (port 0 in LSBs).
- Sub-module prf_ready_table:
  - owns the NUM_PREGS ready bits;
  - takes the alloc, write-set and flush inputs;
  - owns the priority rule: flush restore, then alloc-clear over write-set, then writes after restore.
- The data array and bypass muxing stay in the top module.

Test Plan:
1. Reset mid-run: write 0xDEADBEEF to p5, then assert reset low between edges -> immediately rd_data(p5)=0, ready_vec=all ones.
2. Same-cycle conflict: port0 writes p7=0x11 and port1 writes p7=0x22 -> next cycle read p7 = 0x22, ready = 1.
3. Alloc then writeback: alloc p9 -> rd_ready(p9)=0 next cycle; later write p9=0x1234 -> the same cycle read of p9 returns 0x1234 with ready=1 via bypass; following cycle returns the same from storage.
4. Alloc vs. write collision: alloc p12 and write p12=0x55 in the same cycle -> next cycle data = 0x55, ready = 0.
5. Flush: flush_ready = all ones except p3 = 0, simultaneous write p3=0x77 and alloc p4, with stall=1 -> ready(p3)=1, data(p3)=0x77, ready(p4) unchanged (1).
6. p0 immunity: write p0=0xFFFFFFFF, alloc p0, flush_ready bit 0 = 0 -> reads of p0 return 0 with ready=1 in all cycles; stall=1 with write p20 -> no update, no bypass.
